// File: rtl/cmos_nand_pkg.sv
// Shared constants and helpers for the CMOS NAND gate model.
package cmos_nand_pkg;

   // Default width of the output-transition counter
   localparam int CNT_W_DEF = 8;

   // Supply rails seen by the switch networks
   localparam logic LOGIC_1 = 1'b1;
   localparam logic LOGIC_0 = 1'b0;

   // Switch polarity: p-type conducts on a low gate, n-type on a high gate
   typedef enum logic {
      SW_PMOS = 1'b0,
      SW_NMOS = 1'b1
   } sw_type_e;

   // Returns 1 when a switch of the given polarity conducts for this gate level
   function automatic logic sw_conducts(input sw_type_e sw_type, input logic gate);
      return (sw_type == SW_PMOS) ? ~gate : gate;
   endfunction

endpackage

// File: rtl/cmos_nand_switch.sv
// Single MOS switch: passes its source level to the drain while conducting.
// A non-conducting switch drives its drain low instead of leaving it floating,
// so no Z ever reaches the rest of the design.
module cmos_switch
   import cmos_nand_pkg::*;
#(
   parameter sw_type_e SW_TYPE = SW_NMOS
)(
   input  logic gate,
   input  logic source,
   output logic conduct,
   output logic drain
);

   // Conduction state and the level delivered to the drain node
   always_comb begin
      conduct = sw_conducts(SW_TYPE, gate);
      drain   = conduct ? source : 1'b0;
   end

endmodule

// File: rtl/cmos_nand.sv
// Two-input CMOS NAND: parallel p-type pull-up, series n-type pull-down,
// combinational output plus a registered copy, a saturating transition
// counter and a sticky network-consistency flag.
module cmos_nand
   import cmos_nand_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in1,
   input  logic             in2,
   output logic             out,
   output logic             pu_on,
   output logic             pd_on,
   output logic             out_q,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic             err
);

   logic [1:0] w_gate;
   logic [1:0] w_pu_conduct;
   logic [1:0] w_pu_drain;
   logic       w_pd0_conduct;
   logic       w_pd0_drain;
   logic       w_pd1_conduct;
   logic       w_pd1_drain;
   logic       w_pu_level;

   logic             r_out_q;
   logic [CNT_W-1:0] r_toggle_cnt;
   logic             r_err;

   assign w_gate = {in2, in1};

   // Pull-up: two p-type switches in parallel, each fed from the logic-1 rail
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pull_up
         cmos_switch #(.SW_TYPE(SW_PMOS)) u_pu (
            .gate    (w_gate[gi]),
            .source  (LOGIC_1),
            .conduct (w_pu_conduct[gi]),
            .drain   (w_pu_drain[gi])
         );
      end
   endgenerate

   // Pull-down: two n-type switches in series; the lower one sits on the logic-0 rail
   cmos_switch #(.SW_TYPE(SW_NMOS)) u_pd0 (
      .gate    (in2),
      .source  (LOGIC_0),
      .conduct (w_pd0_conduct),
      .drain   (w_pd0_drain)
   );

   cmos_switch #(.SW_TYPE(SW_NMOS)) u_pd1 (
      .gate    (in1),
      .source  (w_pd0_drain),
      .conduct (w_pd1_conduct),
      .drain   (w_pd1_drain)
   );

   assign pu_on      = |w_pu_conduct;
   assign pd_on      = w_pd0_conduct & w_pd1_conduct;
   assign w_pu_level = w_pu_conduct[0] ? w_pu_drain[0] : w_pu_drain[1];

   // Output node resolution; contention resolves low and a floating node high.
   // Decoded from the network status ports so an externally overridden
   // network state is seen consistently by the output and the error flag.
   always_comb begin
      out = LOGIC_1;
      case ({pu_on, pd_on})
         2'b10:   out = w_pu_level;
         2'b01:   out = w_pd1_drain;
         2'b11:   out = LOGIC_0;
         default: out = LOGIC_1;
      endcase
   end

   // Registered output, saturating transition count and sticky error; reset wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_q      <= LOGIC_1;
         r_toggle_cnt <= '0;
         r_err        <= 1'b0;
      end else begin
         r_out_q <= out;
         if ((out != r_out_q) && (r_toggle_cnt != {CNT_W{1'b1}})) begin
            r_toggle_cnt <= r_toggle_cnt + CNT_W'(1);
         end
         if (pu_on == pd_on) begin
            r_err <= 1'b1;
         end
      end
   end

   assign out_q      = r_out_q;
   assign toggle_cnt = r_toggle_cnt;
   assign err        = r_err;

endmodule

// File: tb/tb_cmos_nand.sv
// Directed testbench for cmos_nand: truth-table vectors with the clock stopped,
// then hand-written clocked sequences on a default and a 2-bit-counter instance.
module tb_cmos_nand;

   logic       clk;
   logic       clk_en;
   logic       rst;
   logic       in1;
   logic       in2;

   logic       out_a, pu_a, pd_a, outq_a, err_a;
   logic [7:0] cnt_a;
   logic       out_b, pu_b, pd_b, outq_b, err_b;
   logic [1:0] cnt_b;

   int checks;
   int errors;

   typedef struct {
      logic a;
      logic b;
      logic exp_out;
      logic exp_pu;
      logic exp_pd;
   } vec_t;

   vec_t vecs [4];

   cmos_nand u_dut (
      .clk        (clk),
      .rst        (rst),
      .in1        (in1),
      .in2        (in2),
      .out        (out_a),
      .pu_on      (pu_a),
      .pd_on      (pd_a),
      .out_q      (outq_a),
      .toggle_cnt (cnt_a),
      .err        (err_a)
   );

   cmos_nand #(.CNT_W(2)) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .in1        (in1),
      .in2        (in2),
      .out        (out_b),
      .pu_on      (pu_b),
      .pd_on      (pd_b),
      .out_q      (outq_b),
      .toggle_cnt (cnt_b),
      .err        (err_b)
   );

   // Clock only toggles while enabled, so the combinational checks run clockless
   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Hard stop in case anything stalls
   initial begin
      #100000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h t=%0t", name, act, exp, $time);
      end else begin
         $display("ok   %s val=%0h t=%0t", name, act, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clk_en = 1'b0;
      rst    = 1'b0;
      in1    = 1'b0;
      in2    = 1'b0;

      vecs[0] = '{a: 1'b0, b: 1'b0, exp_out: 1'b1, exp_pu: 1'b1, exp_pd: 1'b0};
      vecs[1] = '{a: 1'b0, b: 1'b1, exp_out: 1'b1, exp_pu: 1'b1, exp_pd: 1'b0};
      vecs[2] = '{a: 1'b1, b: 1'b0, exp_out: 1'b1, exp_pu: 1'b1, exp_pd: 1'b0};
      vecs[3] = '{a: 1'b1, b: 1'b1, exp_out: 1'b0, exp_pu: 1'b0, exp_pd: 1'b1};

      // Truth table with no clock running, 5 ns per vector
      for (int i = 0; i < 4; i++) begin
         in1 = vecs[i].a;
         in2 = vecs[i].b;
         #1;
         chk($sformatf("tt%0d_out", i),  {31'd0, out_a}, {31'd0, vecs[i].exp_out});
         chk($sformatf("tt%0d_pu", i),   {31'd0, pu_a},  {31'd0, vecs[i].exp_pu});
         chk($sformatf("tt%0d_pd", i),   {31'd0, pd_a},  {31'd0, vecs[i].exp_pd});
         chk($sformatf("tt%0d_out2", i), {31'd0, out_b}, {31'd0, vecs[i].exp_out});
         #4;
      end

      // Reset pulse, then 11 for one cycle, then 00
      clk_en = 1'b1;
      rst = 1'b1; in1 = 1'b0; in2 = 1'b0;
      tick();
      chk("rst_outq", {31'd0, outq_a}, 32'd1);
      chk("rst_cnt",  {24'd0, cnt_a},  32'd0);
      chk("rst_err",  {31'd0, err_a},  32'd0);
      chk("rst_cnt2", {30'd0, cnt_b},  32'd0);
      rst = 1'b0; in1 = 1'b1; in2 = 1'b1;
      tick();
      chk("seq11_outq", {31'd0, outq_a}, 32'd0);
      chk("seq11_cnt",  {24'd0, cnt_a},  32'd1);
      in1 = 1'b0; in2 = 1'b0;
      tick();
      chk("seq00_outq", {31'd0, outq_a}, 32'd1);
      chk("seq00_cnt",  {24'd0, cnt_a},  32'd2);
      chk("seq00_err",  {31'd0, err_a},  32'd0);
      tick();
      chk("hold_cnt",   {24'd0, cnt_a},  32'd2);

      // Reset while the count is 2; combinational path keeps tracking inputs
      rst = 1'b1; in1 = 1'b1; in2 = 1'b1;
      #1;
      chk("rstmid_out_comb", {31'd0, out_a}, 32'd0);
      tick();
      chk("rstmid_outq", {31'd0, outq_a}, 32'd1);
      chk("rstmid_cnt",  {24'd0, cnt_a},  32'd0);
      chk("rstmid_err",  {31'd0, err_a},  32'd0);
      chk("rstmid_out",  {31'd0, out_a},  32'd0);
      chk("rstmid_pd",   {31'd0, pd_a},   32'd1);
      rst = 1'b0;
      tick();
      chk("resume_outq", {31'd0, outq_a}, 32'd0);
      chk("resume_cnt",  {24'd0, cnt_a},  32'd1);

      // Alternate 11/00 for six cycles; the 2-bit counter saturates at 3
      rst = 1'b1; in1 = 1'b0; in2 = 1'b0;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         in1 = (k % 2 == 1);
         in2 = (k % 2 == 1);
         tick();
         chk($sformatf("alt%0d_outq", k), {31'd0, outq_a}, (k % 2 == 1) ? 32'd0 : 32'd1);
         chk($sformatf("alt%0d_cnt", k),  {24'd0, cnt_a},  k);
         chk($sformatf("alt%0d_cnt2", k), {30'd0, cnt_b},  (k < 3) ? k : 3);
      end

      // Glitch in1 between edges with in2=1: only the combinational output moves
      in1 = 1'b0; in2 = 1'b1;
      tick();
      chk("gl_pre_cnt", {24'd0, cnt_a}, 32'd6);
      in1 = 1'b1;
      #1;
      chk("gl_out_low", {31'd0, out_a}, 32'd0);
      in1 = 1'b0;
      #1;
      chk("gl_out_high", {31'd0, out_a}, 32'd1);
      tick();
      chk("gl_outq", {31'd0, outq_a}, 32'd1);
      chk("gl_cnt",  {24'd0, cnt_a},  32'd6);
      chk("gl_err",  {31'd0, err_a},  32'd0);

      // Force both networks on: error sets at the next edge and sticks until reset
      in1 = 1'b1; in2 = 1'b1;
      force u_dut.pu_on = 1'b1;
      #1;
      chk("frc_err_pre", {31'd0, err_a}, 32'd0);
      tick();
      chk("frc_err_set", {31'd0, err_a}, 32'd1);
      chk("frc_out",     {31'd0, out_a}, 32'd0);
      release u_dut.pu_on;
      in1 = 1'b0; in2 = 1'b0;
      tick();
      tick();
      chk("frc_err_sticky", {31'd0, err_a}, 32'd1);
      chk("legal_err2",     {31'd0, err_b}, 32'd0);
      rst = 1'b1;
      tick();
      chk("frc_err_clr", {31'd0, err_a}, 32'd0);
      rst = 1'b0;
      tick();
      chk("post_err", {31'd0, err_a}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
